uart_word_tx: RTL and testbench



---
 rtl/uart_word_tx.sv | 189 ++++++++++++++++++
 tb/tb_uart_word_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: shifts a latched 32-bit word out as four UART frames, LSB byte first.
// Latency: an accepted send (sampled at edge N) drops tx and raises busy at edge N+1;
//   done pulses and busy falls 40*CLKS_PER_BIT (44 with parity) cycles after that.
// Backpressure: none; send is only honoured in IDLE and is dropped while busy (no queuing).
//
// Ports:
//   clk         rising-edge system clock
//   rst         synchronous active-high reset, overrides everything
//   send        start request, sampled only in IDLE
//   data[31:0]  word to transmit, latched on the accepted send
//   busy        high while a word is on the wire
//   done        one-cycle pulse when the fourth stop bit completes
//   tx          registered serial line, idles high
//
// Build option: define UART_TX_PARITY_EN for 8E1 frames (even-parity bit after
// the data bits); left undefined the frames are 8N1 and no parity logic exists.

module uart_word_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  // Keep the timer at least one bit wide so the bad-config path still elaborates
  // far enough to report its own error.
  localparam int TMR_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_word_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [2:0]        bit_q,   bit_d;
  logic [1:0]        byte_q,  byte_d;
  logic [31:0]       shift_q, shift_d;
  logic              tx_q,    tx_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              bit_end;

  // Bit-time boundary: the timer sits at its terminal count for the last
  // cycle of every bit.
  assign bit_end = (timer_q == TMR_LAST);

  // Next-state logic. The current byte always lives in shift_q[7:0]; the word
  // is shifted right by a byte after each stop bit.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    done_d  = 1'b0;

    if (state_q != ST_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (send) begin
          shift_d = data;
          byte_d  = 2'd0;
          bit_d   = 3'd0;
          timer_d = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          // 3-bit index wraps back to 0 after bit 7, ready for the next byte.
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          if (byte_q == 2'd3) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            shift_d = {8'h00, shift_q[31:8]};
            state_d = ST_START;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the *next* state so the registered outputs change on
  // the same edge as the state, with no extra cycle of line latency.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^shift_d[7:0];
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      shift_q <= 32'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx at CLK_FREQ=10, BAUD_RATE=1 (10 clocks per bit).
// Expected line waveform comes from a frame-arithmetic model of the protocol.
// Honours UART_TX_PARITY_EN to switch between 8N1 and 8E1 expectations.

module tb_uart_word_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int BITS = 11;
  localparam bit PAR  = 1'b1;
`else
  localparam int BITS = 10;
  localparam bit PAR  = 1'b0;
`endif
  localparam int TOTAL = 4 * BITS * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        tx;

  int n_chk  = 0;
  int n_pass = 0;

  logic wave [0:TOTAL];

  uart_word_tx #(
    .CLK_FREQ (10),
    .BAUD_RATE(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .send(send),
    .data(data),
    .busy(busy),
    .done(done),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level t cycles after the start bit begins, from the frame layout:
  // start, 8 data bits LSB first, optional even parity, stop; bytes LSB first.
  function automatic logic exp_tx(input logic [31:0] w, input int t);
    int bt, b, pos;
    logic [7:0] by;
    if (t >= TOTAL) return 1'b1;
    bt  = t / CPB;
    b   = bt / BITS;
    pos = bt % BITS;
    by  = 8'(w >> (8 * b));
    if (pos == 0) return 1'b0;
    if (pos <= 8) return by[pos-1];
    if (PAR && pos == 9) return ^by;
    return 1'b1;
  endfunction

  task automatic drive_send(input logic [31:0] w);
    data = w;
    send = 1'b1;
    tick();
  endtask

  // Entered just after the edge that accepted the word (t=0, start bit up).
  task automatic check_word(input logic [31:0] w, input bit hold, input int inj_t,
                            input string tag);
    int bad_tx = 0;
    int bad_busy = 0;
    int bad_done = 0;
    int n_done = 0;
    int first = -1;
    logic [7:0] got_byte;
    for (int t = 0; t <= TOTAL; t++) begin
      if (t > 0) tick();
      wave[t] = tx;
      if (tx !== exp_tx(w, t)) begin
        bad_tx++;
        if (first < 0) first = t;
      end
      if (busy !== (t < TOTAL)) bad_busy++;
      if (done === 1'b1) n_done++;
      if (t < TOTAL && done !== 1'b0) bad_done++;
      if (t == 0 && !hold) send = 1'b0;
      if (inj_t > 0 && t == inj_t) begin
        send = 1'b1;
        data = 32'hDEADBEEF;
      end
      if (inj_t > 0 && t == inj_t + 1) send = 1'b0;
    end
    check($sformatf("%s done_at_end", tag), 32'(done), 32'd1);
    check($sformatf("%s busy_at_end", tag), 32'(busy), 32'd0);
    check($sformatf("%s wave_mismatch(first t=%0d)", tag, first), 32'(bad_tx), 32'd0);
    check($sformatf("%s busy_mismatch", tag), 32'(bad_busy), 32'd0);
    check($sformatf("%s early_done", tag), 32'(bad_done), 32'd0);
    check($sformatf("%s done_count", tag), 32'(n_done), 32'd1);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        got_byte[i] = wave[(b * BITS + 1 + i) * CPB + CPB / 2];
      end
      check($sformatf("%s byte%0d", tag, b), 32'(got_byte), 32'(8'(w >> (8 * b))));
    end
    if (!hold) begin
      tick();
      check($sformatf("%s done_low_after", tag), 32'(done), 32'd0);
      check($sformatf("%s tx_idle_after", tag), 32'(tx), 32'd1);
    end
  endtask

  initial begin
    int idle_bad;
    int stray_done;
    logic [31:0] w;
    logic [7:0] first_bits;

    // Reset held with send asserted: line stays idle, nothing starts.
    rst  = 1'b1;
    send = 1'b1;
    data = $urandom;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_tx%0d", i), 32'(tx), 32'd1);
      check($sformatf("rst_busy%0d", i), 32'(busy), 32'd0);
      check($sformatf("rst_done%0d", i), 32'(done), 32'd0);
    end
    rst  = 1'b0;
    send = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
    end
    check("idle_after_reset", 32'(idle_bad), 32'd0);

    // Single word; first byte 0x44 must read 0,0,1,0,0,0,1,0 after the start bit.
    drive_send(32'h41424344);
    check_word(32'h41424344, 1'b0, -1, "single");
    for (int i = 0; i < 8; i++) first_bits[i] = wave[(1 + i) * CPB + CPB / 2];
    check("single_first_bits", 32'(first_bits), 32'h44);

    // A send while busy is dropped and the in-flight word is not disturbed.
    drive_send(32'h000000FF);
    check_word(32'h000000FF, 1'b0, 50, "ignore_busy");

    // Reset mid-frame truncates with no done, then a fresh word goes out cleanly.
    drive_send(32'h12345678);
    send = 1'b0;
    repeat (149) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    stray_done = 0;
    idle_bad   = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done !== 1'b0) stray_done++;
      if (tx !== 1'b1) idle_bad++;
    end
    check("midrst_no_done", 32'(stray_done), 32'd0);
    check("midrst_line_idle", 32'(idle_bad), 32'd0);
    drive_send(32'h00000055);
    check_word(32'h00000055, 1'b0, -1, "after_rst");

    // Back-to-back with send held: one idle cycle, then the next start bit.
    drive_send(32'hA5A5A5A5);
    check_word(32'hA5A5A5A5, 1'b1, -1, "b2b_first");
    tick();
    check("b2b_start_bit", 32'(tx), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check_word(32'hA5A5A5A5, 1'b0, -1, "b2b_second");

`ifdef UART_TX_PARITY_EN
    // Parity bits for bytes 0x44, 0x07, 0x00, 0x00 are 0,1,0,0.
    drive_send(32'h00000744);
    check_word(32'h00000744, 1'b0, -1, "parity");
    check("parity_b0", 32'(wave[(0 * BITS + 9) * CPB + CPB / 2]), 32'd0);
    check("parity_b1", 32'(wave[(1 * BITS + 9) * CPB + CPB / 2]), 32'd1);
    check("parity_b2", 32'(wave[(2 * BITS + 9) * CPB + CPB / 2]), 32'd0);
    check("parity_b3", 32'(wave[(3 * BITS + 9) * CPB + CPB / 2]), 32'd0);
`endif

    // Random words against the model.
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      drive_send(w);
      check_word(w, 1'b0, -1, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
